// File: rtl/bus_sched_pkg.sv
// Shared types, defaults and field helpers for the bus round-robin scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } sched_state_t;

    localparam int         ID_W_DEF  = 8;
    localparam logic [7:0] BROD_DEF  = 8'hFF;
    localparam int         PKT_MAX_W = 64;
    localparam int         ID_MAX_W  = 16;

    // Packets arrive left-aligned in a PKT_MAX_W container so one helper serves any PCKG.
    function automatic logic [ID_MAX_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt);
        return pkt[PKT_MAX_W-1 -: ID_MAX_W];
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_arb.sv
// Combinational round-robin arbiter: rotate requests past the last winner,
// priority-encode the lowest set bit, then rotate the index back.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  pndng,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW:0]    start_s;
    logic [IW:0]    enc_s;
    logic [IW:0]    sum_s;
    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;

    // Search starts one past the last winner, wrapping at N
    always_comb begin
        start_s = {1'b0, last} + (IW+1)'(1);
        if (start_s == (IW+1)'(N)) begin
            start_s = '0;
        end else begin
            start_s = start_s;
        end
        dbl_s = {pndng, pndng} >> start_s;
        rot_s = dbl_s[N-1:0];
        enc_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                enc_s = (IW+1)'(i);
            end else begin
                enc_s = enc_s;
            end
        end
        sum_s = enc_s + start_s;
        if (sum_s >= (IW+1)'(N)) begin
            sum_s = sum_s - (IW+1)'(N);
        end else begin
            sum_s = sum_s;
        end
        gnt_idx = sum_s[IW-1:0];
        gnt_vld = |pndng;
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin packet-bus scheduler: grant, pop, decode destination, push.
// Broadcast delivery is compiled in only when BUS_BROADCAST_EN is defined.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int              DRIVERS = 4,
    parameter int              PCKG    = 16,
    parameter int              ID_W    = ID_W_DEF,
    parameter logic [ID_W-1:0] BROD    = ID_W'(BROD_DEF),
    localparam int             GW      = $clog2(DRIVERS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DRIVERS-1:0]             pndng,
    input  logic [DRIVERS-1:0][PCKG-1:0]   D_pop,
    output logic [DRIVERS-1:0]             pop,
    output logic [DRIVERS-1:0]             push,
    output logic [PCKG-1:0]                D_push,
    output logic                           bus_busy,
    output logic [GW-1:0]                  grant,
    output logic                           drop
);

    sched_state_t         state_q, state_d;
    logic [DRIVERS-1:0]   pop_q, pop_d, push_q, push_d;
    logic [PCKG-1:0]      dpush_q, dpush_d;
    logic                 busy_q, busy_d, drop_q, drop_d;
    logic [GW-1:0]        grant_q, grant_d, last_q, last_d;
    logic [GW-1:0]        arb_idx_s;
    logic                 arb_vld_s;
    logic [PCKG-1:0]      head_s;
    logic [PKT_MAX_W-1:0] head_al_s;
    logic [ID_W-1:0]      dest_s;
    logic [DRIVERS-1:0]   deliver_s;
    logic                 deliver_ok_s;

    rr_arbiter #(.N(DRIVERS)) u_arb (
        .pndng   (pndng),
        .last    (last_q),
        .gnt_idx (arb_idx_s),
        .gnt_vld (arb_vld_s)
    );

    // Decode the destination of the granted head word into a receiver mask
    always_comb begin
        head_s       = D_pop[grant_q];
        head_al_s    = PKT_MAX_W'(head_s) << (PKT_MAX_W - PCKG);
        dest_s       = ID_W'(dest_of(head_al_s) >> (ID_MAX_W - ID_W));
        deliver_s    = '0;
        deliver_ok_s = 1'b0;
        if (int'(dest_s) < DRIVERS) begin
            deliver_s    = DRIVERS'(1) << dest_s;
            deliver_ok_s = 1'b1;
        end
`ifdef BUS_BROADCAST_EN
        else if (dest_s == BROD) begin
            deliver_s    = ~(DRIVERS'(1) << grant_q);
            deliver_ok_s = 1'b1;
        end
`else
        else if (dest_s == BROD) begin
            deliver_s    = '0;
            deliver_ok_s = 1'b0;
        end
`endif
        else begin
            deliver_s    = '0;
            deliver_ok_s = 1'b0;
        end
    end

    // Next-state and next-output logic; strobes are computed one state ahead
    always_comb begin
        state_d = state_q;
        pop_d   = '0;
        push_d  = '0;
        drop_d  = 1'b0;
        grant_d = grant_q;
        last_d  = last_q;
        dpush_d = dpush_q;
        case (state_q)
            IDLE, PUSH: begin
                if (arb_vld_s) begin
                    grant_d = arb_idx_s;
                    pop_d   = DRIVERS'(1) << arb_idx_s;
                    state_d = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            POP: begin
                if (pndng[grant_q]) begin
                    dpush_d = head_s;
                    last_d  = grant_q;
                    push_d  = deliver_s;
                    drop_d  = ~deliver_ok_s;
                    state_d = PUSH;
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops any packet in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= GW'(DRIVERS - 1);
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign bus_busy = busy_q;
    assign grant    = grant_q;
    assign drop     = drop_q;

endmodule
